// File: rtl/sorted_frame_serializer.sv
// Buffers one sorted frame of N signed elements and streams it out one element per beat.
// Optional SORTED_FRAME_ORDER_CHECK_EN builds the non-decreasing order checker.
module sorted_frame_serializer #(
    parameter int N  = 9,
    parameter int W  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [IW-1:0]   out_index,
    output logic            out_last,
    output logic [15:0]     frame_cnt,
    output logic            order_err,
    output logic [IW-1:0]   err_index
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    function automatic logic [W-1:0] elem_at(input logic [N*W-1:0] frame,
                                             input logic [IW-1:0]  i);
        return frame[int'(i)*W +: W];
    endfunction

    state_t            state_r;
    logic [N*W-1:0]    buf_r;
    logic [IW-1:0]     idx_r;
    logic              out_valid_r;
    logic [W-1:0]      out_data_r;
    logic              out_last_r;
    logic [15:0]       frame_cnt_r;
    logic              accept_s;
    logic [IW-1:0]     next_idx_s;

    assign accept_s   = out_valid_r && out_ready;
    assign next_idx_s = idx_r + IW'(1);

    // Held low during reset so no frame can be captured on a reset edge.
    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = idx_r;
    assign out_last  = out_last_r;
    assign frame_cnt = frame_cnt_r;

    // Capture/stream state machine with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            buf_r       <= '0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        buf_r       <= in_data;
                        idx_r       <= '0;
                        out_data_r  <= in_data[W-1:0];
                        out_last_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept_s) begin
                        if (!out_last_r) begin
                            idx_r      <= next_idx_s;
                            out_data_r <= elem_at(buf_r, next_idx_s);
                            out_last_r <= (next_idx_s == LAST_IDX);
                        end else begin
                            out_valid_r <= 1'b0;
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                            state_r     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef SORTED_FRAME_ORDER_CHECK_EN
    logic [W-1:0]  prev_r;
    logic          order_err_r;
    logic [IW-1:0] err_index_r;

    assign order_err = order_err_r;
    assign err_index = err_index_r;

    // Index 0 is never compared, so the check cannot span frame boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r      <= '0;
            order_err_r <= 1'b0;
            err_index_r <= '0;
        end else if (accept_s) begin
            prev_r <= out_data_r;
            if ((idx_r != '0) && ($signed(out_data_r) < $signed(prev_r)) && !order_err_r) begin
                order_err_r <= 1'b1;
                err_index_r <= idx_r;
            end
        end
    end
`else
    assign order_err = 1'b0;
    assign err_index = '0;
`endif

endmodule

// File: tb/tb_sorted_frame_serializer.sv
// Scoreboard bench for sorted_frame_serializer: expected beats are queued at capture
// and compared as the DUT emits them.
module tb_sorted_frame_serializer;

    localparam int N  = 9;
    localparam int W  = 32;
    localparam int IW = $clog2(N);

`ifdef SORTED_FRAME_ORDER_CHECK_EN
    localparam logic          ERR_EXP     = 1'b1;
    localparam logic [IW-1:0] ERR_IDX_EXP = 4'd2;
`else
    localparam logic          ERR_EXP     = 1'b0;
    localparam logic [IW-1:0] ERR_IDX_EXP = 4'd0;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic [15:0]     frame_cnt;
    logic            order_err;
    logic [IW-1:0]   err_index;

    sorted_frame_serializer #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .frame_cnt(frame_cnt),
        .order_err(order_err), .err_index(err_index)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [IW-1:0] i;
        logic          l;
    } beat_t;

    beat_t                q[$];
    logic signed [W-1:0]  fr [N];
    int                   n_cmp = 0;
    int                   n_err = 0;
    logic                 mon_en = 1'b0;
    logic                 stall_mode = 1'b0;
    int                   ph = 0;
    logic                 hold_v = 1'b0;
    logic [W-1:0]         hold_d;
    logic [IW-1:0]        hold_i;
    logic                 hold_l;
    int                   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_frame();
        logic [N*W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*W +: W] = fr[i];
        return p;
    endfunction

    // Consumer: ready always high, or a 1,0,0 repeating pattern in stall mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: score accepted beats and check outputs hold during stalls.
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_val("hold_data", 64'(out_data), 64'(hold_d));
                check_val("hold_index", 64'(out_index), 64'(hold_i));
                check_val("hold_last", 64'(out_last), 64'(hold_l));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("extra_beat", 64'(out_index), 64'hFFFF);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check_val("beat_data", 64'(out_data), 64'(e.d));
                    check_val("beat_index", 64'(out_index), 64'(e.i));
                    check_val("beat_last", 64'(out_last), 64'(e.l));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_i = out_index;
            hold_l = out_last;
        end
    end

    task automatic send_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check_val("in_ready_timeout", 64'd0, 64'd1);
        in_data  = pack_frame();
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            beat_t e;
            e.d = fr[i];
            e.i = IW'(i);
            e.l = (i == N - 1);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("capture_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(q.size() == 0 && !out_valid) && cycles < 300);
        if (cycles >= 300) check_val("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_index(input logic [IW-1:0] idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_index == idx) && n < 300);
        if (n >= 300) check_val("index_timeout", 64'(out_index), 64'(idx));
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_out_index", 64'(out_index), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_val("rst_order_err", 64'(order_err), 64'd0);
        check_val("rst_err_index", 64'(err_index), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_val("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Full-rate frame: N beats back to back, then idle.
        fr = '{32'sd1, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd11};
        send_frame();
        wait_drain(cyc);
        check_val("throughput_cycles", 64'(cyc), 64'(N));
        check_val("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        check_val("f1_order_err", 64'(order_err), 64'd0);
        check_val("f1_in_ready", 64'(in_ready), 64'd1);

        // Stalled frame with in_data scrambled mid-stream.
        stall_mode = 1'b1;
        send_frame();
        in_data = {(N*W){1'b1}};
        wait_drain(cyc);
        stall_mode = 1'b0;
        check_val("f2_frame_cnt", 64'(frame_cnt), 64'd2);

        // Ordering violation at index 2, second one at index 8.
        fr = '{32'sd1, 32'sd5, 32'sd3, 32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd11, 32'sd4};
        send_frame();
        wait_index(4'd3);
        check_val("err_after_beat3", 64'(order_err), 64'(ERR_EXP));
        check_val("err_idx_after_beat3", 64'(err_index), 64'(ERR_IDX_EXP));
        wait_drain(cyc);
        check_val("err_sticky", 64'(order_err), 64'(ERR_EXP));
        check_val("err_idx_sticky", 64'(err_index), 64'(ERR_IDX_EXP));
        check_val("f3_frame_cnt", 64'(frame_cnt), 64'd3);

        // Signed and equal values, then a back-to-back frame starting at the minimum.
        do_reset();
        fr = '{-32'sd7, -32'sd1, -32'sd1, 32'sd0, 32'sd2, 32'sd2, 32'sd100,
               32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
        send_frame();
        fr = '{32'sh8000_0000, 32'sd0, 32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7};
        send_frame();
        wait_drain(cyc);
        check_val("signed_order_err", 64'(order_err), 64'd0);
        check_val("b2b_frame_cnt", 64'(frame_cnt), 64'd2);

        // Reset in the middle of a frame, then a fresh frame.
        send_frame();
        wait_index(4'd4);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        mon_en = 1'b1;
        fr = '{32'sd9, 32'sd10, 32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15, 32'sd16, 32'sd17};
        send_frame();
        wait_drain(cyc);
        check_val("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
